plic_target_ctrl: RTL and testbench
===================================

PLIC_TARGET_CTRL -- requirements
Module: plic_target_ctrl

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 30: number of interrupt sources, IDs 1..NUM_SOURCES; ID 0 means "no interrupt".
REQ-002 SHALL have parameter PRIORITY_BITWIDTH, default 3: priority and threshold width; priority 0 means never eligible.
REQ-003 SHALL have parameter ID_BITWIDTH, default $clog2(NUM_SOURCES+1): claim and complete ID width.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port irq_sources_i, input, NUM_SOURCES: raw source lines; bit k-1 is ID k.
REQ-007 SHALL have port edge_sel_i, input, NUM_SOURCES: 1 = edge-triggered, 0 = level-triggered, per source.
REQ-008 SHALL have port enable_i, input, NUM_SOURCES: per-source enable for this target.
REQ-009 SHALL have port priorities_i, input, NUM_SOURCES x PRIORITY_BITWIDTH: per-source priority.
REQ-010 SHALL have port threshold_i, input, PRIORITY_BITWIDTH: target priority threshold.
REQ-011 SHALL have port claim_req_i, input, 1: claim request, accepted only when claim_ready_o=1.
REQ-012 SHALL have port claim_ready_o, output, 1: controller can accept a claim.
REQ-013 SHALL have port claim_valid_o, output, 1: one-cycle claim response strobe.
REQ-014 SHALL have port claim_id_o, output, ID_BITWIDTH: claimed ID; valid while claim_valid_o=1, else 0.
REQ-015 SHALL have port complete_i, input, 1: one-cycle completion strobe.
REQ-016 SHALL have port complete_id_i, input, ID_BITWIDTH: ID being completed.
REQ-017 SHALL have port irq_o, output, 1: interrupt request to the target.

Function
REQ-018 Each source SHALL have a gateway FSM with states IDLE, PENDING and CLAIMED, plus one re-arm bit and one sampled-input register.
REQ-019 Level mode: IDLE goes to PENDING on any edge where the source is 1; the source level is ignored in PENDING and CLAIMED.
REQ-020 Edge mode: IDLE goes to PENDING on a rising edge (input 1, sampled value 0); extra edges in PENDING are dropped; an edge in CLAIMED sets re-arm.
REQ-021 A source SHALL be eligible only when it is PENDING, enabled, and has priority > 0; ineligible sources enter arbitration with priority 0.
REQ-022 Arbitration SHALL use plic_find_max over the masked priorities with IDs 1..N; on a tie the lowest ID wins.
REQ-023 The arbitration result SHALL be registered into best_id_q and best_prio_q every cycle (1-cycle latency).
REQ-024 irq_o SHALL equal (best_prio_q > threshold_i); threshold_i applies combinationally.
REQ-025 Latency: a source rising before edge k gives PENDING after edge k and irq_o=1 after edge k+1; equal priority and threshold gives no irq_o.
REQ-026 The controller FSM SHALL have states READY, RESP and SETTLE; claim_ready_o=1 only in READY.
REQ-027 READY with claim_req_i=1: go to RESP; the gateway of best_id_q goes PENDING to CLAIMED on the same edge if irq_o=1.
REQ-028 RESP: claim_valid_o=1 and claim_id_o=best_id_q if irq_o was 1 at acceptance, else 0; then go to SETTLE.
REQ-029 SETTLE: lasts one cycle so best_q refreshes, then go to READY; claim_req_i outside READY is ignored.
REQ-030 Complete: if complete_i=1, complete_id_i is in 1..N and that source is CLAIMED, it leaves CLAIMED on that edge; otherwise the complete is silently ignored (ID 0, out-of-range, not-claimed).
REQ-031 On complete, an edge source goes to PENDING if re-arm is set, else IDLE, and re-arm clears; a level source goes to IDLE and re-pends next edge if still high.
REQ-032 A complete and a claim in the same cycle SHALL both be processed independently.
REQ-033 Disabling a PENDING source SHALL keep it PENDING but ineligible; disabling a CLAIMED source SHALL not affect completion.

Reset
REQ-034 While rst_i=1 at an edge, all gateways SHALL go to IDLE, re-arm and sampled inputs to 0, best_id_q and best_prio_q to 0, and the controller FSM to READY.
REQ-035 After reset: irq_o=0, claim_valid_o=0, claim_id_o=0, claim_ready_o=1.
REQ-036 Reset mid-claim SHALL drop any pending response and release all CLAIMED sources without a complete.

Configuration
REQ-037 Macro PLIC_EDGE_TRIGGER_EN defined: edge_sel_i selects per-source edge or level mode as specified above.
REQ-038 Macro PLIC_EDGE_TRIGGER_EN undefined: all sources are level-triggered, edge_sel_i is ignored, and no re-arm or sampled-input registers are built.

Verification
REQ-039 Source 3 level, prio 2, enabled, threshold 1 -> irq_o=1 two edges later; claim -> claim_id_o=3 in RESP; irq_o=0 after SETTLE.
REQ-040 Sources 2 and 5 both prio 4 -> claim returns 2; complete 2 -> next claim returns 5.
REQ-041 Threshold 3 with max prio 3 -> irq_o=0; claim returns ID 0; source stays PENDING.
REQ-042 Edge source 7 (macro defined): pulse, claim, pulse again while CLAIMED, complete 7 -> PENDING again, claim returns 7.
REQ-043 claim_req_i held high 6 cycles -> exactly 2 claim_valid_o pulses, 3 cycles apart.
REQ-044 Complete for ID 0, ID N+1, or an unclaimed ID -> no state change; reset in RESP -> claim_valid_o=0 next cycle and all sources IDLE.

Source files
------------

// File: rtl/plic_target_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : plic_target_ctrl                                             |
// | Description : Single-target PLIC slice. Per-source gateway FSMs            |
// |               (IDLE/PENDING/CLAIMED), a registered max-priority arbiter,   |
// |               threshold compare and a READY/RESP/SETTLE claim handshake.   |
// | Options     : define PLIC_EDGE_TRIGGER_EN to build per-source edge mode    |
// |               (sampled-input and re-arm registers); otherwise every source |
// |               is level-triggered and edge_sel_i is ignored.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module plic_target_ctrl #(
  parameter int NUM_SOURCES       = 30,
  parameter int PRIORITY_BITWIDTH = 3,
  parameter int ID_BITWIDTH       = $clog2(NUM_SOURCES + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_SOURCES-1:0]                 irq_sources_i,
  input  logic [NUM_SOURCES-1:0]                 edge_sel_i,
  input  logic [NUM_SOURCES-1:0]                 enable_i,
  input  logic [NUM_SOURCES*PRIORITY_BITWIDTH-1:0] priorities_i,
  input  logic [PRIORITY_BITWIDTH-1:0]           threshold_i,
  input  logic                                   claim_req_i,
  output logic                                   claim_ready_o,
  output logic                                   claim_valid_o,
  output logic [ID_BITWIDTH-1:0]                 claim_id_o,
  input  logic                                   complete_i,
  input  logic [ID_BITWIDTH-1:0]                 complete_id_i,
  output logic                                   irq_o
);

  localparam int PW    = PRIORITY_BITWIDTH;
  localparam int ARB_W = ID_BITWIDTH + PRIORITY_BITWIDTH;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  typedef enum logic [1:0] {
    CT_READY  = 2'd0,
    CT_RESP   = 2'd1,
    CT_SETTLE = 2'd2
  } ct_state_e;

  // Highest priority wins; strict '>' while scanning upward keeps the lowest ID on ties.
  function automatic logic [ARB_W-1:0] plic_find_max(
    input logic [NUM_SOURCES*PRIORITY_BITWIDTH-1:0] prio
  );
    logic [ID_BITWIDTH-1:0] id;
    logic [PW-1:0]          mx;
    id = '0;
    mx = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (prio[i*PW +: PW] > mx) begin
        mx = prio[i*PW +: PW];
        id = ID_BITWIDTH'(i + 1);
      end
    end
    return {id, mx};
  endfunction

  logic [NUM_SOURCES*PW-1:0] masked_prio;
  logic [ID_BITWIDTH-1:0]    best_id_q;
  logic [PW-1:0]             best_prio_q;
  ct_state_e                 ct_q, ct_d;
  logic [ID_BITWIDTH-1:0]    resp_id_q, resp_id_d;
  logic                      claim_grant;

  assign irq_o       = (best_prio_q > threshold_i);
  // A grant moves the current winner to CLAIMED; an accepted claim with no irq only returns ID 0.
  assign claim_grant = (ct_q == CT_READY) && claim_req_i && irq_o;

`ifndef PLIC_EDGE_TRIGGER_EN
  logic unused_edge_sel;
  assign unused_edge_sel = ^edge_sel_i;
`endif

  for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_gw
    gw_state_e gw_q, gw_d;
    logic      edge_mode;
    logic      src_rise;
    logic      rearm_now;
    logic      claim_take;
    logic      compl_hit;

    assign claim_take = claim_grant && (best_id_q == ID_BITWIDTH'(k + 1));
    // IDs 0 and anything above NUM_SOURCES match no gateway, so they are ignored here.
    assign compl_hit  = complete_i && (complete_id_i == ID_BITWIDTH'(k + 1));

`ifdef PLIC_EDGE_TRIGGER_EN
    logic samp_q;
    logic rearm_q, rearm_d;

    assign edge_mode = edge_sel_i[k];
    assign src_rise  = irq_sources_i[k] & ~samp_q;
    assign rearm_now = rearm_q;

    // Re-arm remembers one edge seen while claimed; it is consumed by the completion.
    always_comb begin
      rearm_d = rearm_q;
      if (gw_q != GW_CLAIMED) begin
        rearm_d = 1'b0;
      end else if (compl_hit) begin
        rearm_d = 1'b0;
      end else if (edge_mode && src_rise) begin
        rearm_d = 1'b1;
      end
    end

    // Input sampler and re-arm register for edge detection.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        samp_q  <= 1'b0;
        rearm_q <= 1'b0;
      end else begin
        samp_q  <= irq_sources_i[k];
        rearm_q <= rearm_d;
      end
    end
`else
    assign edge_mode = 1'b0;
    assign src_rise  = 1'b0;
    assign rearm_now = 1'b0;
`endif

    // Gateway next state: capture request, hand over on claim, release on complete.
    always_comb begin
      gw_d = gw_q;
      case (gw_q)
        GW_IDLE: begin
          if (edge_mode ? src_rise : irq_sources_i[k]) gw_d = GW_PENDING;
        end
        GW_PENDING: begin
          if (claim_take) gw_d = GW_CLAIMED;
        end
        GW_CLAIMED: begin
          if (compl_hit) gw_d = (edge_mode && rearm_now) ? GW_PENDING : GW_IDLE;
        end
        default: gw_d = GW_IDLE;
      endcase
    end

    // Gateway state register.
    always_ff @(posedge clk_i) begin
      if (rst_i) gw_q <= GW_IDLE;
      else       gw_q <= gw_d;
    end

    // Only pending, enabled sources compete; everything else bids priority 0.
    assign masked_prio[k*PW +: PW] =
      ((gw_q == GW_PENDING) && enable_i[k]) ? priorities_i[k*PW +: PW] : '0;
  end

  // Registered arbitration result, refreshed every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_id_q   <= '0;
      best_prio_q <= '0;
    end else begin
      {best_id_q, best_prio_q} <= plic_find_max(masked_prio);
    end
  end

  // Claim handshake: accept in READY, answer in RESP, let best_q refresh in SETTLE.
  always_comb begin
    ct_d          = ct_q;
    resp_id_d     = resp_id_q;
    claim_ready_o = 1'b0;
    claim_valid_o = 1'b0;
    claim_id_o    = '0;
    case (ct_q)
      CT_READY: begin
        claim_ready_o = 1'b1;
        if (claim_req_i) begin
          ct_d      = CT_RESP;
          resp_id_d = irq_o ? best_id_q : '0;
        end
      end
      CT_RESP: begin
        claim_valid_o = 1'b1;
        claim_id_o    = resp_id_q;
        ct_d          = CT_SETTLE;
      end
      CT_SETTLE: begin
        ct_d = CT_READY;
      end
      default: ct_d = CT_READY;
    endcase
  end

  // Controller state and latched response ID.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ct_q      <= CT_READY;
      resp_id_q <= '0;
    end else begin
      ct_q      <= ct_d;
      resp_id_q <= resp_id_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plic_target_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_plic_target_ctrl                                          |
// | Description : Scoreboard bench for plic_target_ctrl: directed scenarios    |
// |               plus randomized traffic against a behavioural model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_plic_target_ctrl;

  localparam int N   = 30;
  localparam int P   = 3;
  localparam int IDW = $clog2(N + 1);
`ifdef PLIC_EDGE_TRIGGER_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  localparam int S_IDLE = 0, S_PEND = 1, S_CLAIM = 2;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   src = '0, edge_sel = '0, en = '0;
  logic [N*P-1:0] prios = '0;
  logic [P-1:0]   thr = '0;
  logic           claim_req = 1'b0, complete = 1'b0;
  logic [IDW-1:0] complete_id = '0;
  logic           claim_ready, claim_valid, irq;
  logic [IDW-1:0] claim_id;

  int n_checks = 0, n_err = 0;
  bit mon_en = 1'b0;
  int last_claim_id = -1;

  // Behavioural model state (IDs 1..N; index 0 unused).
  int m_st [0:N];
  bit m_rearm [0:N];
  bit m_samp [0:N];
  int m_best_id = 0, m_best_prio = 0, m_phase = 0;  // phase: 0 ready, 1 resp, 2 settle
  int exp_q [$];

  plic_target_ctrl #(.NUM_SOURCES(N), .PRIORITY_BITWIDTH(P), .ID_BITWIDTH(IDW)) dut (
    .clk_i(clk), .rst_i(rst_i), .irq_sources_i(src), .edge_sel_i(edge_sel),
    .enable_i(en), .priorities_i(prios), .threshold_i(thr),
    .claim_req_i(claim_req), .claim_ready_o(claim_ready), .claim_valid_o(claim_valid),
    .claim_id_o(claim_id), .complete_i(complete), .complete_id_i(complete_id), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_prio(input int id, input int v);
    prios[(id-1)*P +: P] = P'(v);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    src = '0; edge_sel = '0; en = '0; prios = '0; thr = '0;
    claim_req = 1'b0; complete = 1'b0; complete_id = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic do_claim();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete = 1'b1;
    complete_id = IDW'(id);
    tick();
    complete = 1'b0;
    complete_id = '0;
  endtask

  // Reference model: evaluated from the rules at every rising edge.
  always @(posedge clk) begin
    int nid, np, p;
    bit acc, grant, lvl, rise, edg;
    if (rst_i) begin
      for (int k = 0; k <= N; k++) begin
        m_st[k] = S_IDLE; m_rearm[k] = 1'b0; m_samp[k] = 1'b0;
      end
      m_best_id = 0; m_best_prio = 0; m_phase = 0;
      exp_q.delete();
    end else begin
      nid = 0; np = 0;
      for (int k = 1; k <= N; k++) begin
        p = (m_st[k] == S_PEND && en[k-1]) ? int'(prios[(k-1)*P +: P]) : 0;
        if (p > np) begin np = p; nid = k; end
      end
      acc   = (m_phase == 0) && claim_req;
      grant = acc && (m_best_prio > int'(thr));
      for (int k = 1; k <= N; k++) begin
        lvl  = src[k-1];
        edg  = EDGE_EN && edge_sel[k-1];
        rise = lvl && !m_samp[k];
        if (m_st[k] == S_IDLE) begin
          if (edg ? rise : lvl) m_st[k] = S_PEND;
        end else if (m_st[k] == S_PEND) begin
          if (grant && m_best_id == k) m_st[k] = S_CLAIM;
        end else begin
          if (complete && int'(complete_id) == k) begin
            m_st[k] = (edg && m_rearm[k]) ? S_PEND : S_IDLE;
            m_rearm[k] = 1'b0;
          end else if (edg && rise) begin
            m_rearm[k] = 1'b1;
          end
        end
        if (m_st[k] != S_CLAIM) m_rearm[k] = 1'b0;
        m_samp[k] = lvl;
      end
      if (acc) begin
        exp_q.push_back(grant ? m_best_id : 0);
        m_phase = 1;
      end else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2) m_phase = 0;
      m_best_id = nid;
      m_best_prio = np;
    end
  end

  // Monitor: compares the observable outputs and pops the scoreboard on every response.
  always @(negedge clk) begin
    int e;
    if (mon_en) begin
      chk("irq_o", irq, (m_best_prio > int'(thr)) ? 1 : 0);
      chk("claim_ready_o", claim_ready, (m_phase == 0) ? 1 : 0);
      chk("claim_valid_o", claim_valid, (m_phase == 1) ? 1 : 0);
      if (claim_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL claim_unexpected: got id %0d expected no response at %0t", claim_id, $time);
        end else begin
          e = exp_q.pop_front();
          chk("claim_id_o", claim_id, e);
        end
        last_claim_id = int'(claim_id);
      end else begin
        chk("claim_id_idle", claim_id, 0);
      end
    end
  end

  initial begin
    int pulses, first_at, second_at, cid;
    do_reset();
    mon_en = 1'b1;
    chk("reset_irq", irq, 0);
    chk("reset_ready", claim_ready, 1);
    chk("reset_valid", claim_valid, 0);
    chk("reset_id", claim_id, 0);

    // Single level source, claim, settle.
    en = '1; set_prio(3, 2); thr = 1;
    src[2] = 1'b1;
    tick(); tick();
    chk("lvl_irq_two_edges", irq, 1);
    do_claim();
    chk("lvl_resp_valid", claim_valid, 1);
    chk("lvl_resp_id3", claim_id, 3);
    tick();
    chk("lvl_irq_after_settle", irq, 0);
    tick();
    src[2] = 1'b0;
    do_complete(3);
    tick();

    // Tie on priority, lowest ID first; complete and claim together.
    do_reset();
    en = '1; set_prio(2, 4); set_prio(5, 4);
    src[1] = 1'b1; src[4] = 1'b1;
    tick(); tick();
    do_claim();
    chk("tie_first_id2", claim_id, 2);
    tick(); tick();
    src[1] = 1'b0;
    claim_req = 1'b1; complete = 1'b1; complete_id = IDW'(2);
    tick();
    claim_req = 1'b0; complete = 1'b0; complete_id = '0;
    chk("tie_next_id5", claim_id, 5);
    tick(); tick();

    // Threshold equal to max priority.
    do_reset();
    en = '1; set_prio(4, 3); thr = 3;
    src[3] = 1'b1;
    tick(); tick();
    chk("thr_eq_no_irq", irq, 0);
    do_claim();
    chk("thr_eq_valid", claim_valid, 1);
    chk("thr_eq_id0", claim_id, 0);
    tick(); tick();
    thr = 2;
    #1;
    chk("thr_still_pending", irq, 1);

`ifdef PLIC_EDGE_TRIGGER_EN
    // Edge source re-armed while claimed.
    do_reset();
    en = '1; edge_sel[6] = 1'b1; set_prio(7, 5);
    src[6] = 1'b1; tick(); src[6] = 1'b0;
    tick();
    chk("edge_irq", irq, 1);
    do_claim();
    chk("edge_first_id7", claim_id, 7);
    tick(); tick();
    src[6] = 1'b1; tick(); src[6] = 1'b0; tick();
    do_complete(7);
    tick();
    chk("edge_rearm_irq", irq, 1);
    do_claim();
    chk("edge_second_id7", claim_id, 7);
    tick(); tick();
`endif

    // Claim request held for six cycles.
    do_reset();
    en = '1; set_prio(3, 2); set_prio(9, 1);
    src[2] = 1'b1; src[8] = 1'b1;
    tick(); tick();
    claim_req = 1'b1;
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (claim_valid === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i; else second_at = i;
      end
      if (i == 6) claim_req = 1'b0;
    end
    chk("held_pulse_count", pulses, 2);
    chk("held_pulse_gap", second_at - first_at, 3);

    // Bogus completes, then reset during RESP.
    do_reset();
    en = '1; set_prio(3, 2); set_prio(5, 2);
    src[2] = 1'b1;
    tick(); tick();
    do_claim();
    tick(); tick();
    do_complete(0);
    do_complete(N + 1);
    do_complete(4);
    tick(); tick();
    chk("bogus_complete_no_irq", irq, 0);
    src[4] = 1'b1;
    tick(); tick();
    do_claim();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_resp_valid", claim_valid, 0);
    chk("rst_resp_ready", claim_ready, 1);
    tick(); tick();
    do_claim();
    chk("rst_released_id3", claim_id, 3);
    tick(); tick();

    // Randomized traffic against the model.
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      for (int k = 1; k <= N; k++) begin
        set_prio(k, $urandom_range(0, (1 << P) - 1));
        en[k-1] = ($urandom_range(0, 9) < 8);
        edge_sel[k-1] = $urandom_range(0, 1);
      end
      thr = P'($urandom_range(0, 4));
      for (int c = 0; c < 250; c++) begin
        for (int k = 0; k < N; k++) if ($urandom_range(0, 9) == 0) src[k] = ~src[k];
        claim_req = ($urandom_range(0, 9) < 3);
        complete = ($urandom_range(0, 3) == 0);
        cid = $urandom_range(0, N + 1);
        if ($urandom_range(0, 1) == 1)
          for (int k = 1; k <= N; k++) if (m_st[k] == S_CLAIM) cid = k;
        complete_id = IDW'(cid);
        if ($urandom_range(0, 19) == 0) thr = P'($urandom_range(0, (1 << P) - 1));
        rst_i = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    rst_i = 1'b0; claim_req = 1'b0; complete = 1'b0;
    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
